// File: rtl/comb_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// comb_seq_pkg
// Shared types and helpers for the comb_seq_ctrl stimulus sequencer.
//   state_t  : sequencer FSM states (IDLE, WAIT, SAMPLE, DONE)
//   GRAY_W   : widest vector index supported (N_IN max is 6)
//   bin2gray : binary to reflected Gray code, x ^ (x >> 1)
// -----------------------------------------------------------------------------
package comb_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int GRAY_W = 6;

   // Callers zero-extend their index to GRAY_W and truncate the result back;
   // the Gray transform never moves bits upward, so this is width-safe.
   function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] x);
      return x ^ (x >> 1);
   endfunction

endpackage

// File: rtl/comb_seq_ctrl_settle_timer.sv
// -----------------------------------------------------------------------------
// seq_settle_timer
// Counts the settle window for each stimulus vector.
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset
//   load    : hold the count at zero (asserted whenever the FSM is not in WAIT)
//   expired : high for the single cycle in which the count equals SETTLE-1
// Parameter SETTLE (>= 1): number of cycles in the window.
// -----------------------------------------------------------------------------
module seq_settle_timer #(
   parameter int SETTLE = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic expired
);

   localparam int CW = $clog2(SETTLE + 1);
   localparam logic [CW-1:0] C_LAST = CW'(SETTLE - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= '0;
      end else if (r_cnt != C_LAST) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // Gated by load so that SETTLE=1 (C_LAST=0) does not fire while parked.
   assign expired = !load && (r_cnt == C_LAST);

endmodule

// File: rtl/comb_seq_ctrl.sv
// -----------------------------------------------------------------------------
// comb_seq_ctrl
// Exhaustive Gray-order stimulus sequencer and self-checker for a small
// combinational DUT. Each vector is held for SETTLE cycles, then dut_y is
// compared against exp_tbl[stim] and mismatches are accumulated.
//   clk, rst_n : clock and synchronous active-low reset
//   start      : begin a sweep (accepted in IDLE or DONE only)
//   abort      : cancel a running sweep (ignored in IDLE and DONE)
//   exp_tbl    : expected output per vector value, held stable during a sweep
//   dut_y      : output of the DUT being checked
//   stim       : DUT input vector, MSB is bit N_IN-1
//   busy       : sweep in progress
//   done       : last sweep completed (level)
//   pass       : done and no mismatches
//   err_cnt    : number of mismatching vectors
//   fail_vec   : bit k set when vector value k mismatched
// -----------------------------------------------------------------------------
module comb_seq_ctrl
   import comb_seq_pkg::*;
#(
   parameter int N_IN   = 2,
   parameter int SETTLE = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   input  logic [(2**N_IN)-1:0]   exp_tbl,
   input  logic                   dut_y,
   output logic [N_IN-1:0]        stim,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [N_IN:0]          err_cnt,
   output logic [(2**N_IN)-1:0]   fail_vec
);

   localparam int NV = 2**N_IN;
   localparam logic [N_IN-1:0] IDX_LAST = N_IN'(NV - 1);

   state_t              r_state;
   state_t              w_next_state;

   logic [N_IN-1:0]     r_idx;
   logic [N_IN-1:0]     r_stim;
   logic [N_IN:0]       r_err_cnt;
   logic [NV-1:0]       r_fail_vec;

   logic                w_expired;
   logic                w_timer_load;
   logic                w_accept_start;
   logic                w_sample;
   logic                w_abort_hit;
   logic                w_last;
   logic                w_mismatch;
   logic [N_IN-1:0]     w_idx_next;
   logic [N_IN-1:0]     w_gray_idx;
   logic [N_IN-1:0]     w_gray_next;

   // ---------------------------------------------------------------------------
   // Settle window timer
   // ---------------------------------------------------------------------------
   assign w_timer_load = (r_state != WAIT);

   seq_settle_timer #(
      .SETTLE (SETTLE)
   ) u_settle (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (w_timer_load),
      .expired (w_expired)
   );

   // ---------------------------------------------------------------------------
   // Vector indexing and compare
   // ---------------------------------------------------------------------------
   assign w_idx_next  = r_idx + N_IN'(1);
   assign w_last      = (r_idx == IDX_LAST);
   assign w_gray_idx  = N_IN'(bin2gray(GRAY_W'(r_idx)));
   assign w_gray_next = N_IN'(bin2gray(GRAY_W'(w_idx_next)));
   assign w_mismatch  = (dut_y != exp_tbl[w_gray_idx]);

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next state and datapath strobes
   // ---------------------------------------------------------------------------
   always_comb begin
      w_next_state   = r_state;
      w_accept_start = 1'b0;
      w_sample       = 1'b0;
      w_abort_hit    = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_accept_start = 1'b1;
               w_next_state   = WAIT;
            end
         end
         WAIT: begin
            if (abort) begin
               w_abort_hit  = 1'b1;
               w_next_state = IDLE;
            end else if (w_expired) begin
               w_next_state = SAMPLE;
            end
         end
         SAMPLE: begin
            // An abort landing on the sample cycle wins; the vector is not scored.
            if (abort) begin
               w_abort_hit  = 1'b1;
               w_next_state = IDLE;
            end else begin
               w_sample     = 1'b1;
               w_next_state = w_last ? DONE : WAIT;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Index, stimulus and result registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_idx      <= '0;
         r_stim     <= '0;
         r_err_cnt  <= '0;
         r_fail_vec <= '0;
      end else begin
         if (w_accept_start) begin
            r_idx      <= '0;
            r_stim     <= '0;
            r_err_cnt  <= '0;
            r_fail_vec <= '0;
         end
         if (w_abort_hit) begin
            r_stim <= '0;
         end
         if (w_sample) begin
            if (w_mismatch) begin
               r_err_cnt              <= r_err_cnt + (N_IN+1)'(1);
               r_fail_vec[w_gray_idx] <= 1'b1;
            end
            if (!w_last) begin
               r_idx  <= w_idx_next;
               r_stim <= w_gray_next;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign stim     = r_stim;
   assign busy     = (r_state == WAIT) || (r_state == SAMPLE);
   assign done     = (r_state == DONE);
   assign pass     = done && (r_err_cnt == '0);
   assign err_cnt  = r_err_cnt;
   assign fail_vec = r_fail_vec;

endmodule

// File: tb/tb_comb_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_comb_seq_ctrl
// Bench for comb_seq_ctrl: instance A uses N_IN=2/SETTLE=10, instance B uses
// N_IN=3/SETTLE=1. The DUT under test of each sequencer is a truth table
// held in the bench; expected results come from the Gray order constants and
// the XOR/popcount of the two tables.
// -----------------------------------------------------------------------------
module tb_comb_seq_ctrl;

   logic       clk;
   logic       rst_n;

   logic       start_a, abort_a;
   logic [3:0] exp_tbl_a, dut_tbl_a;
   logic       dut_y_a;
   logic [1:0] stim_a;
   logic       busy_a, done_a, pass_a;
   logic [2:0] err_a;
   logic [3:0] fv_a;

   logic       start_b, abort_b;
   logic [7:0] exp_tbl_b, dut_tbl_b;
   logic       dut_y_b;
   logic [2:0] stim_b;
   logic       busy_b, done_b, pass_b;
   logic [3:0] err_b;
   logic [7:0] fv_b;

   logic       sel_b;
   logic [7:0] g_stim, g_fv;
   logic [3:0] g_err;
   logic       g_busy, g_done, g_pass;

   int n_cmp;
   int n_bad;

   int ORD_A [4] = '{0, 1, 3, 2};
   int ORD_B [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

   typedef struct {
      bit         inst;
      logic [7:0] e;
      logic [7:0] d;
      int         rp;
      logic [3:0] xerr;
      logic [7:0] xfv;
   } vec_t;

   vec_t tbl [5];

   comb_seq_ctrl #(.N_IN(2), .SETTLE(10)) u_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start_a),
      .abort    (abort_a),
      .exp_tbl  (exp_tbl_a),
      .dut_y    (dut_y_a),
      .stim     (stim_a),
      .busy     (busy_a),
      .done     (done_a),
      .pass     (pass_a),
      .err_cnt  (err_a),
      .fail_vec (fv_a)
   );

   comb_seq_ctrl #(.N_IN(3), .SETTLE(1)) u_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start_b),
      .abort    (abort_b),
      .exp_tbl  (exp_tbl_b),
      .dut_y    (dut_y_b),
      .stim     (stim_b),
      .busy     (busy_b),
      .done     (done_b),
      .pass     (pass_b),
      .err_cnt  (err_b),
      .fail_vec (fv_b)
   );

   // Behavioural combinational DUTs
   assign dut_y_a = dut_tbl_a[stim_a];
   assign dut_y_b = dut_tbl_b[stim_b];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      if (sel_b) begin
         g_stim = 8'(stim_b);
         g_fv   = fv_b;
         g_err  = err_b;
         g_busy = busy_b;
         g_done = done_b;
         g_pass = pass_b;
      end else begin
         g_stim = 8'(stim_a);
         g_fv   = 8'(fv_a);
         g_err  = 4'(err_a);
         g_busy = busy_a;
         g_done = done_a;
         g_pass = pass_a;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive_start(input bit inst, input logic v);
      if (inst) start_b = v;
      else      start_a = v;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_stim"},  32'(g_stim), 32'd0);
      chk({tag, "_busy"},  32'(g_busy), 32'd0);
      chk({tag, "_done"},  32'(g_done), 32'd0);
      chk({tag, "_pass"},  32'(g_pass), 32'd0);
      chk({tag, "_err"},   32'(g_err),  32'd0);
      chk({tag, "_fvec"},  32'(g_fv),   32'd0);
   endtask

   // Full sweep from start pulse to done; rp>0 re-pulses start at that cycle.
   task automatic run_sweep(input bit inst, input logic [7:0] e, input logic [7:0] d,
                            input int rp, input logic [3:0] xerr, input logic [7:0] xfv);
      int nv, per, total, k, xs;
      nv    = inst ? 8 : 4;
      per   = inst ? 2 : 11;
      total = nv * per;
      sel_b = inst;
      if (inst) begin
         exp_tbl_b = e;
         dut_tbl_b = d;
      end else begin
         exp_tbl_a = e[3:0];
         dut_tbl_a = d[3:0];
      end
      drive_start(inst, 1'b1);
      @(negedge clk);
      drive_start(inst, 1'b0);
      for (int n = 1; n <= total + 1; n++) begin
         if (n <= total) begin
            k  = (n - 1) / per;
            xs = inst ? ORD_B[k] : ORD_A[k];
            chk("stim_step", 32'(g_stim), 32'(xs));
            chk("busy_sweep", 32'(g_busy), 32'd1);
            chk("done_early", 32'(g_done), 32'd0);
            drive_start(inst, n == rp);
            @(negedge clk);
         end else begin
            xs = inst ? ORD_B[nv-1] : ORD_A[nv-1];
            chk("done_rise", 32'(g_done), 32'd1);
            chk("busy_fall", 32'(g_busy), 32'd0);
            chk("stim_hold", 32'(g_stim), 32'(xs));
            chk("err_cnt",   32'(g_err),  32'(xerr));
            chk("fail_vec",  32'(g_fv),   32'(xfv));
            chk("pass",      32'(g_pass), 32'(xerr == 4'd0));
         end
      end
      drive_start(inst, 1'b0);
   endtask

   initial begin
      logic [7:0] re, rd, rfv;
      bit         rinst;

      n_cmp     = 0;
      n_bad     = 0;
      rst_n     = 1'b0;
      start_a   = 1'b0;
      abort_a   = 1'b0;
      start_b   = 1'b0;
      abort_b   = 1'b0;
      exp_tbl_a = '0;
      dut_tbl_a = '0;
      exp_tbl_b = '0;
      dut_tbl_b = '0;
      sel_b     = 1'b0;

      // inst, exp_tbl, dut truth table, start re-pulse cycle, expected err, expected fail_vec
      tbl[0] = '{inst:1'b0, e:8'h02, d:8'h02, rp:0,  xerr:4'd0, xfv:8'h00}; // ~a&b, correct table
      tbl[1] = '{inst:1'b0, e:8'h04, d:8'h02, rp:25, xerr:4'd2, xfv:8'h06}; // wrong table, start re-pulsed in vector 2
      tbl[2] = '{inst:1'b0, e:8'h0F, d:8'h00, rp:0,  xerr:4'd4, xfv:8'h0F}; // every vector fails
      tbl[3] = '{inst:1'b1, e:8'h96, d:8'h96, rp:0,  xerr:4'd0, xfv:8'h00}; // 3-input XOR
      tbl[4] = '{inst:1'b0, e:8'h02, d:8'h0F, rp:0,  xerr:4'd3, xfv:8'h0D}; // output stuck at 1

      repeat (2) @(negedge clk);
      sel_b = 1'b0;
      chk_all_zero("rst_a");
      sel_b = 1'b1;
      chk_all_zero("rst_b");
      rst_n = 1'b1;
      @(negedge clk);
      chk_all_zero("idle_b");
      sel_b = 1'b0;
      chk_all_zero("idle_a");

      for (int i = 0; i < 5; i++) begin
         run_sweep(tbl[i].inst, tbl[i].e, tbl[i].d, tbl[i].rp, tbl[i].xerr, tbl[i].xfv);
      end

      // A is in DONE after the stuck-at-1 sweep: abort must be ignored.
      sel_b   = 1'b0;
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      chk("abort_in_done_done", 32'(g_done), 32'd1);
      chk("abort_in_done_err",  32'(g_err),  32'd3);

      // start in DONE clears results on the next cycle.
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      chk("restart_done", 32'(g_done), 32'd0);
      chk("restart_err",  32'(g_err),  32'd0);
      chk("restart_fvec", 32'(g_fv),   32'd0);
      chk("restart_busy", 32'(g_busy), 32'd1);

      // abort sampled at T0+20: vector 0 already scored (stuck-1 vs 0).
      repeat (19) @(negedge clk);
      chk("pre_abort_err", 32'(g_err), 32'd1);
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      chk("abort_busy", 32'(g_busy), 32'd0);
      chk("abort_stim", 32'(g_stim), 32'd0);
      chk("abort_done", 32'(g_done), 32'd0);
      chk("abort_pass", 32'(g_pass), 32'd0);
      chk("abort_err",  32'(g_err),  32'd1);
      chk("abort_fvec", 32'(g_fv),   32'h1);

      // abort in IDLE is ignored.
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      chk("abort_idle_busy", 32'(g_busy), 32'd0);
      chk("abort_idle_err",  32'(g_err),  32'd1);

      // Reset sampled at T0+30 of a new sweep.
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (29) @(negedge clk);
      chk("pre_rst_busy", 32'(g_busy), 32'd1);
      chk("pre_rst_err",  32'(g_err),  32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk_all_zero("midrst");
      rst_n = 1'b1;
      @(negedge clk);
      chk_all_zero("postrst");

      // Randomized sweeps against the table-difference model.
      for (int r = 0; r < 8; r++) begin
         rinst = r[0];
         re    = 8'($urandom);
         rd    = 8'($urandom);
         if (!rinst) begin
            re = re & 8'h0F;
            rd = rd & 8'h0F;
         end
         rfv = re ^ rd;
         run_sweep(rinst, re, rd, 0, 4'($countones(rfv)), rfv);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
